// File: rtl/memory_arbiter.sv
// Two-port arbiter/sequencer in front of the 64K x 16 stack memory.
// Define MEMARB_FIXED_PRIO_EN for fixed priority (port 0 wins ties).
module memory_arbiter #(
    parameter int AW = 16,
    parameter int DW = 16
) (
    input  logic          c_CLOCK,
    input  logic          c_RESETn,
    input  logic          i_REQ0,
    input  logic          i_REQ1,
    input  logic          i_WE0,
    input  logic          i_WE1,
    input  logic [AW-1:0] i_ADDR0,
    input  logic [AW-1:0] i_ADDR1,
    input  logic [DW-1:0] i_WDATA0,
    input  logic [DW-1:0] i_WDATA1,
    output logic          o_GNT0,
    output logic          o_GNT1,
    output logic          o_RVALID0,
    output logic          o_RVALID1,
    output logic [DW-1:0] o_OP1,
    output logic [DW-1:0] o_OP2,
    output logic          o_BUSY,
    output logic [AW-1:0] o_RADDR,
    output logic [AW-1:0] o_WADDR,
    output logic [DW-1:0] o_DATA,
    output logic          o_WRITE,
    input  logic [DW-1:0] i_OP1,
    input  logic [DW-1:0] i_OP2
);

    typedef enum logic [1:0] {
        IDLE,
        RD_ADDR,
        RD_DATA,
        WR
    } state_e;

    state_e        state_q, state_d;
    logic          port_q, port_d;
    logic          gnt0_q, gnt0_d;
    logic          gnt1_q, gnt1_d;
    logic          rv0_q, rv0_d;
    logic          rv1_q, rv1_d;
    logic          write_q, write_d;
    logic [AW-1:0] raddr_q, raddr_d;
    logic [AW-1:0] waddr_q, waddr_d;
    logic [DW-1:0] data_q, data_d;
    logic [DW-1:0] op1_q, op1_d;
    logic [DW-1:0] op2_q, op2_d;

    logic          any_req;
    logic          win;
    logic          win_we;
    logic [AW-1:0] win_addr;
    logic [DW-1:0] win_wdata;

    assign any_req = i_REQ0 | i_REQ1;

`ifdef MEMARB_FIXED_PRIO_EN
    // Port 0 wins whenever it asks.
    assign win = ~i_REQ0;
`else
    // prio_q names the port that wins the next tie.
    logic prio_q, prio_d;

    assign win = (i_REQ0 & i_REQ1) ? prio_q : i_REQ1;

    // Round-robin pointer: reset favours port 0.
    always_ff @(posedge c_CLOCK or negedge c_RESETn) begin
        if (!c_RESETn) prio_q <= 1'b0;
        else           prio_q <= prio_d;
    end

    // The loser of each grant becomes the preferred port.
    always_comb begin
        prio_d = prio_q;
        if (state_q == IDLE && any_req) prio_d = ~win;
    end
`endif

    assign win_we    = win ? i_WE1    : i_WE0;
    assign win_addr  = win ? i_ADDR1  : i_ADDR0;
    assign win_wdata = win ? i_WDATA1 : i_WDATA0;

    // State and every output are registered; reset aborts any access.
    always_ff @(posedge c_CLOCK or negedge c_RESETn) begin
        if (!c_RESETn) begin
            state_q <= IDLE;
            port_q  <= 1'b0;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            rv0_q   <= 1'b0;
            rv1_q   <= 1'b0;
            write_q <= 1'b0;
            raddr_q <= '0;
            waddr_q <= '0;
            data_q  <= '0;
            op1_q   <= '0;
            op2_q   <= '0;
        end else begin
            state_q <= state_d;
            port_q  <= port_d;
            gnt0_q  <= gnt0_d;
            gnt1_q  <= gnt1_d;
            rv0_q   <= rv0_d;
            rv1_q   <= rv1_d;
            write_q <= write_d;
            raddr_q <= raddr_d;
            waddr_q <= waddr_d;
            data_q  <= data_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
        end
    end

    // Sequencer: only IDLE samples requests; pulses default low.
    always_comb begin
        state_d = state_q;
        port_d  = port_q;
        gnt0_d  = 1'b0;
        gnt1_d  = 1'b0;
        rv0_d   = 1'b0;
        rv1_d   = 1'b0;
        write_d = 1'b0;
        raddr_d = raddr_q;
        waddr_d = waddr_q;
        data_d  = data_q;
        op1_d   = op1_q;
        op2_d   = op2_q;
        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    port_d = win;
                    gnt0_d = ~win;
                    gnt1_d = win;
                    if (win_we) begin
                        state_d = WR;
                        write_d = 1'b1;
                        waddr_d = win_addr;
                        data_d  = win_wdata;
                    end else begin
                        state_d = RD_ADDR;
                        raddr_d = win_addr;
                    end
                end
            end
            RD_ADDR: state_d = RD_DATA;
            RD_DATA: begin
                state_d = IDLE;
                op1_d   = i_OP1;
                op2_d   = i_OP2;
                rv0_d   = ~port_q;
                rv1_d   = port_q;
            end
            WR:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign o_GNT0    = gnt0_q;
    assign o_GNT1    = gnt1_q;
    assign o_RVALID0 = rv0_q;
    assign o_RVALID1 = rv1_q;
    assign o_OP1     = op1_q;
    assign o_OP2     = op2_q;
    assign o_BUSY    = (state_q != IDLE);
    assign o_RADDR   = raddr_q;
    assign o_WADDR   = waddr_q;
    assign o_DATA    = data_q;
    assign o_WRITE   = write_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// Scoreboard bench for memory_arbiter with a registered-read memory model.
// Build with MEMARB_FIXED_PRIO_EN to expect fixed-priority grant order.
module tb_memory_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0 = 0, req1 = 0, we0 = 0, we1 = 0;
    logic [15:0] addr0 = 0, addr1 = 0, wd0 = 0, wd1 = 0;
    logic        gnt0, gnt1, rv0, rv1, busy, wr;
    logic [15:0] op1, op2, raddr, waddr, data;
    logic [15:0] m_op1 = 0, m_op2 = 0;
    logic [15:0] mem [0:65535];
    logic [15:0] ra_m1;
    int          cyc = 0;
    int          n_vec = 0, n_bad = 0;
    int          last_gnt = 0;

    typedef struct {
        bit          rv;
        bit          port;
        logic [15:0] op1;
        logic [15:0] op2;
    } exp_t;
    exp_t sb[$];
    exp_t me;

    memory_arbiter #(.AW(16), .DW(16)) dut (
        .c_CLOCK(clk), .c_RESETn(rst_n),
        .i_REQ0(req0), .i_REQ1(req1), .i_WE0(we0), .i_WE1(we1),
        .i_ADDR0(addr0), .i_ADDR1(addr1),
        .i_WDATA0(wd0), .i_WDATA1(wd1),
        .o_GNT0(gnt0), .o_GNT1(gnt1),
        .o_RVALID0(rv0), .o_RVALID1(rv1),
        .o_OP1(op1), .o_OP2(op2), .o_BUSY(busy),
        .o_RADDR(raddr), .o_WADDR(waddr), .o_DATA(data),
        .o_WRITE(wr), .i_OP1(m_op1), .i_OP2(m_op2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory: 1-cycle registered read of addr and addr-1.
    assign ra_m1 = raddr - 16'd1;
    always @(posedge clk) begin
        if (wr) mem[waddr] <= data;
        m_op1 <= mem[raddr];
        m_op2 <= mem[ra_m1];
    end

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: invariants every cycle, scoreboard on each GNT/RVALID.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("invariant", {28'd0, gnt0 & gnt1, rv0 & rv1, wr & ~busy,
                $isunknown({gnt0, gnt1, rv0, rv1, busy, wr,
                            op1, op2, raddr, waddr, data})}, 32'd0);
            if (gnt0 | gnt1 | rv0 | rv1) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL unexpected: gnt=%b%b rv=%b%b, none expected",
                             gnt1, gnt0, rv1, rv0);
                end else begin
                    me = sb.pop_front();
                    if (!me.rv) begin
                        chk("gnt_port", {30'd0, gnt1, gnt0}, me.port ? 2 : 1);
                        chk("gnt_no_rv", {30'd0, rv1, rv0}, 0);
                        last_gnt = cyc;
                    end else begin
                        chk("rv_port", {30'd0, rv1, rv0}, me.port ? 2 : 1);
                        chk("op1", {16'd0, op1}, {16'd0, me.op1});
                        chk("op2", {16'd0, op2}, {16'd0, me.op2});
                        chk("rd_latency", cyc - last_gnt, 2);
                    end
                end
            end
        end
    end

    task automatic req_on(bit p, bit we, logic [15:0] a, logic [15:0] d);
        if (p) begin req1 = 1; we1 = we; addr1 = a; wd1 = d; end
        else   begin req0 = 1; we0 = we; addr0 = a; wd0 = d; end
    endtask

    task automatic req_off(bit p);
        if (p) req1 = 0;
        else   req0 = 0;
    endtask

    task automatic push_gnt(bit p);
        exp_t e;
        e.rv = 0; e.port = p; e.op1 = 0; e.op2 = 0;
        sb.push_back(e);
    endtask

    task automatic push_rd(bit p, logic [15:0] o1, logic [15:0] o2);
        exp_t e;
        push_gnt(p);
        e.rv = 1; e.port = p; e.op1 = o1; e.op2 = o2;
        sb.push_back(e);
    endtask

    // Waits up to 20 cycles for a grant; n = cycles waited, -1 on timeout.
    task automatic wait_gnt(bit p, output int n);
        n = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (p ? gnt1 : gnt0) begin n = i; break; end
        end
        if (n < 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL gnt_timeout: port %0d got no grant, want one", p);
        end
    endtask

    task automatic wait_any_gnt(output int p);
        p = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (gnt0 | gnt1) begin p = gnt1 ? 1 : 0; break; end
        end
        if (p < 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL any_gnt_timeout: no grant, want one");
        end
    endtask

    task automatic wait_idle();
        bit ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!busy) begin ok = 1; break; end
        end
        if (!ok) begin
            n_vec++;
            n_bad++;
            $display("FAIL idle_timeout: busy stuck high, want low");
        end
    endtask

    task automatic all_zero(string name);
        chk({name, "_ctl"}, {26'd0, gnt0, gnt1, rv0, rv1, busy, wr}, 0);
        chk({name, "_adr"}, {raddr, waddr}, 0);
        chk({name, "_dat"}, {16'd0, data | op1 | op2}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n, p, t0;
        int exp_p [4];
        for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
        mem[16'h0000] = 16'h0F0F;
        mem[16'h000F] = 16'h1234;
        mem[16'h0010] = 16'hABCD;
        mem[16'h0021] = 16'h2121;
        mem[16'h0030] = 16'h3030;
        mem[16'hFFFF] = 16'hBEEF;

        // Reset state
        repeat (3) @(negedge clk);
        all_zero("reset");
        rst_n = 1;
        repeat (2) @(negedge clk);

        // 1: port0 read 0x0010
        req_on(0, 0, 16'h0010, 0);
        push_rd(0, 16'hABCD, 16'h1234);
        wait_gnt(0, n);
        chk("t1_gnt_lat", n, 1);
        chk("t1_raddr", {16'd0, raddr}, 32'h0010);
        chk("t1_busy", {31'd0, busy}, 1);
        req_off(0);
        wait_idle();

        // 2: port1 write 0x0020 <- 0x5555, then read 0x0021
        req_on(1, 1, 16'h0020, 16'h5555);
        push_gnt(1);
        wait_gnt(1, n);
        chk("t2_gnt_lat", n, 1);
        chk("t2_write", {31'd0, wr}, 1);
        chk("t2_wport", {waddr, data}, 32'h0020_5555);
        req_off(1);
        @(negedge clk);
        chk("t2_write_drop", {30'd0, wr, busy}, 0);
        req_on(1, 0, 16'h0021, 0);
        push_rd(1, 16'h2121, 16'h5555);
        wait_gnt(1, n);
        chk("t2_rd_lat", n, 1);
        chk("t2_waddr_hold", {waddr, data}, 32'h0020_5555);
        req_off(1);
        wait_idle();

        // 3: both ports held for four reads
`ifdef MEMARB_FIXED_PRIO_EN
        exp_p = '{0, 0, 0, 0};
`else
        exp_p = '{0, 1, 0, 1};
`endif
        for (int k = 0; k < 4; k++) begin
            if (exp_p[k] == 1) push_rd(1, 16'h2121, 16'h5555);
            else               push_rd(0, 16'hABCD, 16'h1234);
        end
        req_on(0, 0, 16'h0010, 0);
        req_on(1, 0, 16'h0021, 0);
        for (int k = 0; k < 4; k++) begin
            wait_any_gnt(p);
            chk($sformatf("t3_order%0d", k), p, exp_p[k]);
        end
        req_off(0);
        req_off(1);
        wait_idle();
        @(negedge clk);

        // 4: read 0x0000 wraps to mem[FFFF] for OP2
        req_on(0, 0, 16'h0000, 0);
        push_rd(0, 16'h0F0F, 16'hBEEF);
        wait_gnt(0, n);
        req_off(0);
        wait_idle();
        chk("t4_op_hold", {op1, op2}, 32'h0F0F_BEEF);

        // 5: reset during a write
        req_on(1, 1, 16'h0030, 16'h7777);
        push_gnt(1);
        wait_gnt(1, n);
        req_off(1);
        #2 rst_n = 0;
        #1 chk("t5_write_drop", {31'd0, wr}, 0);
        all_zero("t5_abort");
        @(negedge clk);
        rst_n = 1;
        chk("t5_mem_kept", {16'd0, mem[16'h0030]}, 32'h3030);
        chk("t5_sb_empty", sb.size(), 0);
        repeat (2) @(negedge clk);
        req_on(0, 0, 16'h0030, 0);
        push_rd(0, 16'h3030, 16'h0000);
        wait_gnt(0, n);
        req_off(0);
        wait_idle();
        @(negedge clk);

        // 6: back-to-back reads on port 0, request held
        for (int g = 0; g < 3; g++) push_rd(0, 16'hABCD, 16'h1234);
        req_on(0, 0, 16'h0010, 0);
        t0 = 0;
        for (int g = 0; g < 3; g++) begin
            wait_gnt(0, n);
            if (g > 0) chk($sformatf("t6_spacing%0d", g), cyc - t0, 3);
            t0 = cyc;
            chk("t6_busy_c1", {31'd0, busy}, 1);
            if (g == 2) req_off(0);
            @(negedge clk);
            chk("t6_busy_c2", {31'd0, busy}, 1);
            @(negedge clk);
            chk("t6_busy_c3", {31'd0, busy}, 0);
        end

        repeat (5) @(negedge clk);
        chk("sb_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
